// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the 7N link TX/RX
package uart_pkg;

  localparam int UART_DATA_BITS = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  typedef logic [UART_DATA_BITS-1:0] uart_word_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with a one-cycle tick at terminal count
module uart_baud_gen #(
  parameter int p_clks_per_bit = 868
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int            CW = $clog2(p_clks_per_bit);
  localparam logic [CW-1:0] TC = CW'(p_clks_per_bit - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == TC)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TC);

endmodule

// File: rtl/uart_7n_tx.sv
// rtl/uart_7n_tx.sv - 7N UART transmitter draining a first-word-fall-through FIFO
module uart_7n_tx
  import uart_pkg::*;
#(
  parameter int p_word_size    = 8,
  parameter int p_clks_per_bit = 868,
  parameter int p_stop_bits    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [p_word_size-1:0] fifo_data_i,
  input  logic                   fifo_valid_i,
  output logic                   fifo_read_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(p_stop_bits - 1);

  uart_tx_state_t state_q;
  uart_word_t     shift_q;
  logic [2:0]     bit_idx_q;
  logic           stop_idx_q;
  logic           tx_q;
  logic           busy_q;

  logic tick;
  logic frame_end;
  logic pop;
  logic unused_fifo_hi;

  assign unused_fifo_hi = ^fifo_data_i;

  assign frame_end = (state_q == STOP) && tick && (stop_idx_q == LAST_STOP);
  // Gating with rst_n_i keeps the FIFO from being drained while held in reset.
  assign pop = rst_n_i && fifo_valid_i && ((state_q == IDLE) || frame_end);

  uart_baud_gen #(
    .p_clks_per_bit(p_clks_per_bit)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clear_i((state_q == IDLE) || pop),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else if (pop) begin
      shift_q    <= fifo_data_i[UART_DATA_BITS-1:0];
      state_q    <= START;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        START: if (tick) begin
          state_q   <= DATA;
          bit_idx_q <= '0;
          tx_q      <= shift_q[0];
        end
        DATA: if (tick) begin
          shift_q <= shift_q >> 1;
          tx_q    <= shift_q[1];
          if (bit_idx_q == LAST_BIT) begin
            state_q    <= STOP;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
        end
        STOP: if (tick) begin
          if (stop_idx_q == LAST_STOP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            stop_idx_q <= stop_idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_read_o  = pop;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_end;

endmodule

// File: tb/tb_uart_7n_tx.sv
// tb/tb_uart_7n_tx.sv - directed bench for uart_7n_tx with behavioural FIFOs
module tb_uart_7n_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO 1 feeds the one-stop-bit instance, FIFO 2 the two-stop-bit instance.
  logic [7:0]  f1_mem [8];
  logic [31:0] f1_wr = 0;
  logic [31:0] f1_rd = 0;
  logic        f1_valid, f1_read, tx1, busy1, done1;
  logic [7:0]  f1_data;

  logic [7:0]  f2_mem [8];
  logic [31:0] f2_wr = 0;
  logic [31:0] f2_rd = 0;
  logic        f2_valid, f2_read, tx2, busy2, done2;
  logic [7:0]  f2_data;

  assign f1_valid = (f1_wr != f1_rd);
  assign f1_data  = f1_mem[f1_rd[2:0]];
  assign f2_valid = (f2_wr != f2_rd);
  assign f2_data  = f2_mem[f2_rd[2:0]];

  always @(posedge clk) if (f1_read && f1_valid) f1_rd <= f1_rd + 1;
  always @(posedge clk) if (f2_read && f2_valid) f2_rd <= f2_rd + 1;

  uart_7n_tx #(.p_word_size(8), .p_clks_per_bit(4), .p_stop_bits(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(f1_data), .fifo_valid_i(f1_valid),
    .fifo_read_o(f1_read), .tx_o(tx1), .busy_o(busy1), .frame_done_o(done1)
  );

  uart_7n_tx #(.p_word_size(8), .p_clks_per_bit(4), .p_stop_bits(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .fifo_data_i(f2_data), .fifo_valid_i(f2_valid),
    .fifo_read_o(f2_read), .tx_o(tx2), .busy_o(busy2), .frame_done_o(done2)
  );

  task automatic push1(input logic [7:0] d);
    f1_mem[f1_wr[2:0]] = d;
    f1_wr = f1_wr + 1;
  endtask

  task automatic push2(input logic [7:0] d);
    f2_mem[f2_wr[2:0]] = d;
    f2_wr = f2_wr + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tx1, f1_read, busy1, done1} !== 4'b1000) begin
      bad++; $display("FAIL reset_dut1 got=%b exp=1000", {tx1, f1_read, busy1, done1});
    end
    total++;
    if ({tx2, f2_read, busy2, done2} !== 4'b1000) begin
      bad++; $display("FAIL reset_dut2 got=%b exp=1000", {tx2, f2_read, busy2, done2});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if ({tx1, f1_read, busy1, tx2, f2_read, busy2} !== 6'b100100) begin
        bad++; $display("FAIL idle cyc=%0d got=%b exp=100100", i, {tx1, f1_read, busy1, tx2, f2_read, busy2});
      end
    end
  endtask

  task automatic test_single_frame(input logic [7:0] word, input logic [8:0] line);
    logic [31:0] rd0;
    @(negedge clk);
    rd0 = f1_rd;
    push1(word);
    #1;
    total++;
    if (f1_read !== 1'b1) begin
      bad++; $display("FAIL single_pop word=%h got=%b exp=1", word, f1_read);
    end
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      total++;
      if (tx1 !== line[i/4] || done1 !== (i == 35) || busy1 !== 1'b1) begin
        bad++; $display("FAIL single_frame word=%h cyc=%0d got tx/done/busy=%b%b%b exp=%b%b1",
                        word, i, tx1, done1, busy1, line[i/4], (i == 35));
      end
    end
    @(negedge clk);
    total++;
    if ({tx1, busy1, done1} !== 3'b100 || (f1_rd - rd0) !== 32'd1) begin
      bad++; $display("FAIL single_end word=%h got tx/busy/done=%b pops=%0d exp=100 pops=1",
                      word, {tx1, busy1, done1}, f1_rd - rd0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd0;
    logic [26:0] line;
    line = {9'h100, 9'h1FE, 9'h102};
    @(negedge clk);
    rd0 = f1_rd;
    push1(8'h01); push1(8'h7F); push1(8'h00);
    #1;
    total++;
    if (f1_read !== 1'b1) begin
      bad++; $display("FAIL b2b_first_pop got=%b exp=1", f1_read);
    end
    for (int i = 0; i < 108; i++) begin
      @(negedge clk);
      total++;
      if (tx1 !== line[i/4] || done1 !== ((i % 36) == 35) || f1_read !== (i == 35 || i == 71)
          || busy1 !== 1'b1) begin
        bad++; $display("FAIL b2b cyc=%0d got tx/done/read/busy=%b%b%b%b exp=%b%b%b1", i,
                        tx1, done1, f1_read, busy1, line[i/4], ((i % 36) == 35), (i == 35 || i == 71));
      end
    end
    @(negedge clk);
    total++;
    if ({tx1, busy1} !== 2'b10 || (f1_rd - rd0) !== 32'd3) begin
      bad++; $display("FAIL b2b_end got tx/busy=%b pops=%0d exp=10 pops=3", {tx1, busy1}, f1_rd - rd0);
    end
  endtask

  task automatic test_mid_frame_two_stop;
    logic [31:0] rd0;
    logic [19:0] line;
    line = {10'h32A, 10'h354};
    @(negedge clk);
    rd0 = f2_rd;
    push2(8'h2A);
    #1;
    total++;
    if (f2_read !== 1'b1) begin
      bad++; $display("FAIL mid_first_pop got=%b exp=1", f2_read);
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      total++;
      if (tx2 !== line[i/4] || done2 !== (i == 39 || i == 79) || f2_read !== (i == 39)
          || busy2 !== 1'b1) begin
        bad++; $display("FAIL mid_frame cyc=%0d got tx/done/read/busy=%b%b%b%b exp=%b%b%b1", i,
                        tx2, done2, f2_read, busy2, line[i/4], (i == 39 || i == 79), (i == 39));
      end
      if (i == 9) push2(8'h15);
    end
    @(negedge clk);
    total++;
    if ({tx2, busy2} !== 2'b10 || (f2_rd - rd0) !== 32'd2) begin
      bad++; $display("FAIL mid_end got tx/busy=%b pops=%0d exp=10 pops=2", {tx2, busy2}, f2_rd - rd0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd0;
    logic [8:0]  line;
    line = 9'h198;
    @(negedge clk);
    rd0 = f1_rd;
    push1(8'h33); push1(8'h4C);
    #1;
    total++;
    if (f1_read !== 1'b1) begin
      bad++; $display("FAIL rst_first_pop got=%b exp=1", f1_read);
    end
    repeat (17) @(negedge clk);
    total++;
    if (tx1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++; $display("FAIL rst_before_bit3 got tx/busy=%b%b exp=01", tx1, busy1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({tx1, busy1, f1_read} !== 3'b100) begin
      bad++; $display("FAIL rst_async got tx/busy/read=%b exp=100", {tx1, busy1, f1_read});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({tx1, busy1, f1_read} !== 3'b100 || (f1_rd - rd0) !== 32'd1) begin
        bad++; $display("FAIL rst_hold cyc=%0d got tx/busy/read=%b pops=%0d exp=100 pops=1",
                        i, {tx1, busy1, f1_read}, f1_rd - rd0);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (f1_read !== 1'b1) begin
      bad++; $display("FAIL rst_release_pop got=%b exp=1", f1_read);
    end
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      total++;
      if (tx1 !== line[i/4] || done1 !== (i == 35) || f1_read !== 1'b0) begin
        bad++; $display("FAIL rst_next_frame cyc=%0d got tx/done/read=%b%b%b exp=%b%b0",
                        i, tx1, done1, f1_read, line[i/4], (i == 35));
      end
    end
    @(negedge clk);
    total++;
    if ({tx1, busy1} !== 2'b10 || (f1_rd - rd0) !== 32'd2 || f1_valid !== 1'b0) begin
      bad++; $display("FAIL rst_end got tx/busy=%b pops=%0d valid=%b exp=10 pops=2 valid=0",
                      {tx1, busy1}, f1_rd - rd0, f1_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame(8'h55, 9'h1AA);
    test_single_frame(8'hD5, 9'h1AA);
    test_back_to_back;
    test_mid_frame_two_stop;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
